// File: rtl/sram_arbiter.sv
// Two-port SRAM-channel arbiter: fetch (read-only) and data (read/write) share one bridge channel.
// One transaction in flight; request fields are registered and held until the bridge responds.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1,
  localparam int SEL_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_done,
  output logic [DATA_W-1:0] inst_read_data,
  input  logic              data_en,
  input  logic [SEL_W-1:0]  data_write_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_write_data,
  output logic              data_done,
  output logic [DATA_W-1:0] data_read_data,
  output logic              mem_en,
  input  logic              mem_ready,
  output logic [SEL_W-1:0]  mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  // state | meaning
  // IDLE  | waiting for a request; winner is chosen and latched here
  // ISSUE | mem_en high until the bridge accepts
  // WAIT  | bridge busy; fields held, read data captured when mem_ready returns
  // RESP  | one-cycle done pulse to the granted port
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   grant_data;
  logic   pick_data;
  logic   is_read;

  // grant_data doubles as the last-grant record for round-robin ties
  assign pick_data = data_en & (~inst_en | DATA_FIRST | ~grant_data);
  assign is_read   = (mem_write_en == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inst_en | data_en) state_nxt = ISSUE;
      ISSUE:   if (mem_ready) state_nxt = WAIT;
      WAIT:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      grant_data     <= 1'b0;
      mem_write_en   <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      inst_read_data <= '0;
      data_read_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (inst_en | data_en)) begin
        grant_data     <= pick_data;
        mem_addr       <= pick_data ? data_addr : inst_addr;
        mem_write_en   <= pick_data ? data_write_en : '0;
        mem_write_data <= pick_data ? data_write_data : '0;
      end
      if (state == WAIT && mem_ready && is_read) begin
        if (grant_data) data_read_data <= mem_read_data;
        else            inst_read_data <= mem_read_data;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign inst_done = (state == RESP) & ~grant_data;
  assign data_done = (state == RESP) & grant_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a bridge model checks issued fields, a done monitor checks returned data.
// A second instance with round-robin arbitration checks tie-breaking order.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_done;
  logic [31:0] inst_read_data;
  logic        data_en = 1'b0;
  logic [3:0]  data_write_en = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_write_data = '0;
  logic        data_done;
  logic [31:0] data_read_data;
  logic        mem_en;
  logic        mem_ready;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        rr_inst_en = 1'b0;
  logic [31:0] rr_inst_addr = '0;
  logic        rr_inst_done;
  logic [31:0] rr_inst_read_data;
  logic        rr_data_en = 1'b0;
  logic [31:0] rr_data_addr = '0;
  logic        rr_data_done;
  logic [31:0] rr_data_read_data;
  logic        rr_mem_en;
  logic        rr_mem_ready = 1'b1;
  logic [3:0]  rr_mem_write_en;
  logic [31:0] rr_mem_addr;
  logic [31:0] rr_mem_write_data;
  logic [31:0] rr_mem_read_data = 32'h0000_0000;
  logic [3:0]  rr_zero_we = '0;
  logic [31:0] rr_zero_wd = '0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_done(inst_done), .inst_read_data(inst_read_data),
    .data_en(data_en), .data_write_en(data_write_en), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_done(data_done), .data_read_data(data_read_data),
    .mem_en(mem_en), .mem_ready(mem_ready), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_en(rr_inst_en), .inst_addr(rr_inst_addr), .inst_done(rr_inst_done),
    .inst_read_data(rr_inst_read_data),
    .data_en(rr_data_en), .data_write_en(rr_zero_we), .data_addr(rr_data_addr),
    .data_write_data(rr_zero_wd), .data_done(rr_data_done), .data_read_data(rr_data_read_data),
    .mem_en(rr_mem_en), .mem_ready(rr_mem_ready), .mem_write_en(rr_mem_write_en),
    .mem_addr(rr_mem_addr), .mem_write_data(rr_mem_write_data), .mem_read_data(rr_mem_read_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
  } issue_t;

  issue_t      issue_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic [31:0] data_rd_model = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy = 0;
  int          stall_n = 0;
  int          stall_seen = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_8000;
    return (a ^ 32'h5A5A_A5A5) + 32'd17;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bridge model: accepts on mem_en&mem_ready, stays busy for `busy` cycles, aborts on reset
  initial begin
    logic [31:0] acc_addr;
    logic [3:0]  acc_we;
    logic [31:0] acc_wd;
    issue_t      e;
    int          nst;
    bit          aborted;
    mem_ready     = 1'b1;
    mem_read_data = '0;
    nst           = 0;
    forever begin
      @(negedge clk);
      if (!mem_en && stall_n > 0 && mem_ready) mem_ready = 1'b0;
      if (mem_en && !mem_ready) begin
        nst++;
        if (issue_q.size() > 0) begin
          check("stall_addr", mem_addr, issue_q[0].addr);
          check("stall_we", {28'd0, mem_write_en}, {28'd0, issue_q[0].we});
        end
        check("stall_nodone", {30'd0, inst_done, data_done}, 32'd0);
        if (nst >= stall_n) begin
          stall_seen = nst;
          nst        = 0;
          stall_n    = 0;
          @(posedge clk);
          #1 mem_ready = 1'b1;
        end
      end else if (mem_en && mem_ready) begin
        acc_addr = mem_addr;
        acc_we   = mem_write_en;
        acc_wd   = mem_write_data;
        check("issue_pending", {31'd0, issue_q.size() > 0}, 32'd1);
        if (issue_q.size() > 0) begin
          e = issue_q.pop_front();
          check("issue_addr", acc_addr, e.addr);
          check("issue_we", {28'd0, acc_we}, {28'd0, e.we});
          check("issue_wd", acc_wd, e.wd);
        end
        @(posedge clk);
        #1;
        aborted = 1'b0;
        if (busy > 0) begin
          mem_ready = 1'b0;
          for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            if (!rst) begin
              aborted = 1'b1;
              break;
            end
            check("wait_mem_en", {31'd0, mem_en}, 32'd0);
            check("wait_addr", mem_addr, acc_addr);
            check("wait_we", {28'd0, mem_write_en}, {28'd0, acc_we});
            check("wait_wd", mem_write_data, acc_wd);
            @(posedge clk);
          end
          if (!aborted) #1;
        end
        mem_read_data = rdata_of(acc_addr);
        mem_ready     = 1'b1;
      end
    end
  end

  // done monitor: pops the per-port scoreboard on every done pulse
  initial begin
    logic pi, pd;
    pi = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (inst_done | data_done) check("done_excl", {31'd0, inst_done & data_done}, 32'd0);
      if (inst_done) begin
        check("inst_pulse", {31'd0, pi}, 32'd0);
        check("inst_q_pending", {31'd0, inst_q.size() > 0}, 32'd1);
        if (inst_q.size() > 0) check("inst_rdata", inst_read_data, inst_q.pop_front());
      end
      if (data_done) begin
        check("data_pulse", {31'd0, pd}, 32'd0);
        check("data_q_pending", {31'd0, data_q.size() > 0}, 32'd1);
        if (data_q.size() > 0) check("data_rdata", data_read_data, data_q.pop_front());
      end
      pi = inst_done;
      pd = data_done;
    end
  end

  task automatic fetch(input logic [31:0] a, input bit push_issue, output int done_cyc);
    int n;
    n         = 0;
    inst_addr = a;
    inst_en   = 1'b1;
    inst_q.push_back(rdata_of(a));
    if (push_issue) issue_q.push_back('{a, 4'b0000, 32'd0});
    do begin
      @(negedge clk);
      n++;
    end while (!inst_done && n < 100);
    check("inst_done_seen", {31'd0, inst_done}, 32'd1);
    done_cyc = cyc;
    @(posedge clk);
    #1 inst_en = 1'b0;
  endtask

  task automatic data_acc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input bit push_issue, output int done_cyc);
    int n;
    n               = 0;
    data_addr       = a;
    data_write_en   = we;
    data_write_data = wd;
    data_en         = 1'b1;
    if (we == 4'b0000) data_rd_model = rdata_of(a);
    data_q.push_back(data_rd_model);
    if (push_issue) issue_q.push_back('{a, we, wd});
    do begin
      @(negedge clk);
      n++;
    end while (!data_done && n < 100);
    check("data_done_seen", {31'd0, data_done}, 32'd1);
    done_cyc = cyc;
    @(posedge clk);
    #1 data_en = 1'b0;
  endtask

  task automatic rr_wait_issue(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rr_mem_en && n < 50);
    check(tag, rr_mem_addr, exp);
  endtask

  task automatic rr_wait_done(input string tag, input bit want_data);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_data ? rr_data_done : rr_inst_done) && n < 50);
    check(tag, {31'd0, want_data ? rr_data_done : rr_inst_done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, c2, start, prev;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_done", {30'd0, inst_done, data_done}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // round-robin instance: reset grant is inst, so a tie goes to data, then alternates
    rr_inst_addr = 32'h0000_0100;
    rr_data_addr = 32'h0000_0200;
    rr_inst_en   = 1'b1;
    rr_data_en   = 1'b1;
    rr_wait_issue("rr_tie_after_reset", 32'h0000_0200);
    rr_wait_done("rr_data_done", 1'b1);
    rr_data_addr = 32'h0000_0300;
    rr_wait_issue("rr_tie_last_data", 32'h0000_0100);
    rr_wait_done("rr_inst_done", 1'b0);
    rr_inst_addr = 32'h0000_0104;
    rr_wait_issue("rr_tie_last_inst", 32'h0000_0300);
    rr_wait_done("rr_data_done2", 1'b1);
    rr_inst_en = 1'b0;
    rr_data_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // reset-vector fetch through a 3-cycle busy bridge
    busy  = 3;
    start = cyc;
    fetch(32'hBFC0_0000, 1'b1, c);
    check("fetch_latency", c - start, 32'd6);

    // load, then a halfword store that must leave the load data alone, then an odd strobe
    busy = 2;
    data_acc(32'h8000_0200, 4'b0000, 32'd0, 1'b1, c);
    busy = 4;
    data_acc(32'h8000_0102, 4'b0011, 32'h0000_BEEF, 1'b1, c);
    busy = 1;
    data_acc(32'h8000_0104, 4'b0101, 32'h1234_5678, 1'b1, c);

    // simultaneous requests: data wins, fetch follows right after data's response
    busy = 1;
    issue_q.push_back('{32'h8000_0300, 4'b0000, 32'd0});
    issue_q.push_back('{32'h0000_0040, 4'b0000, 32'd0});
    fork
      fetch(32'h0000_0040, 1'b0, c);
      data_acc(32'h8000_0300, 4'b0000, 32'd0, 1'b0, c2);
    join
    check("tie_order_gap", c - c2, 32'd5);

    // bridge refuses for 5 cycles
    busy    = 0;
    stall_n = 5;
    fetch(32'h0000_1000, 1'b1, c);
    check("stall_cycles", stall_seen, 32'd5);

    // reset while the bridge is busy
    busy = 6;
    issue_q.push_back('{32'h0000_2000, 4'b0000, 32'd0});
    inst_addr = 32'h0000_2000;
    inst_en   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    inst_en = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_mem_en", {31'd0, mem_en}, 32'd0);
    check("mrst_done", {30'd0, inst_done, data_done}, 32'd0);
    check("mrst_mem_addr", mem_addr, 32'd0);
    check("mrst_mem_we", {28'd0, mem_write_en}, 32'd0);
    check("mrst_mem_wd", mem_write_data, 32'd0);
    check("mrst_inst_rd", inst_read_data, 32'd0);
    check("mrst_data_rd", data_read_data, 32'd0);
    rst           = 1'b1;
    data_rd_model = '0;
    busy          = 2;
    fetch(32'h0000_3000, 1'b1, c);

    // eight back-to-back fetches with a zero-wait bridge
    busy = 0;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      fetch(32'h0000_0400 + 32'(i * 4), 1'b1, c);
      if (i > 0) check("b2b_period", c - prev, 32'd4);
      prev = c;
    end

    repeat (3) @(posedge clk);
    #1;
    check("issue_q_drained", issue_q.size(), 32'd0);
    check("inst_q_drained", inst_q.size(), 32'd0);
    check("data_q_drained", data_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
